// File: rtl/load_store_unit.sv
// load_store_unit: multicycle aligned load/store engine for a single-port word RAM.
// Sub-word stores read the word, merge the new lane and write it back.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;
    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        illegal;
    logic        misaligned;
    logic        err_in;
    logic [4:0]  sh_b;
    logic [4:0]  sh_h;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;
    always_comb begin
        accept     = state == IDLE && start_i;
        illegal    = we_i ? (funct3_i[2] || funct3_i[1:0] == 2'b11)
                          : (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11);
        misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                     (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
        err_in     = illegal || misaligned;
    end
    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        sh_b      = {off_q, 3'b000};
        sh_h      = {off_q[1], 4'b0000};
        byte_lane = 8'(ram_data_i >> sh_b);
        half_lane = off_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
            3'b100:  load_val = {24'b0, byte_lane};
            3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
            3'b101:  load_val = {16'b0, half_lane};
            default: load_val = ram_data_i;
        endcase
        merged = f3_q[0]
            ? (ram_data_i & ~(32'h0000FFFF << sh_h)) | ({16'b0, wdata_q} << sh_h)
            : (ram_data_i & ~(32'h000000FF << sh_b)) | ({24'b0, wdata_q[7:0]} << sh_b);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !accept ? IDLE
                              : err_in ? DONE
                              : (we_i && funct3_i[1:0] == 2'b10) ? WRITE : READ;
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = we_q ? WRITE : DONE;
            WRITE:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b0;
            off_q     <= 2'b0;
            wdata_q   <= 16'b0;
            addr_q    <= 32'b0;
            wr_data_q <= 32'b0;
            rdata_q   <= 32'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            we_q    <= we_i;
            f3_q    <= funct3_i;
            off_q   <= addr_i[1:0];
            wdata_q <= wdata_i[15:0];
            err_q   <= err_in;
            if (!err_in) begin
                addr_q    <= {addr_i[31:2], 2'b00};
                wr_data_q <= wdata_i;
            end
        end else if (state == CAPTURE) begin
            if (we_q) wr_data_q <= merged;
            else      rdata_q   <= load_val;
        end
    end
    always_comb begin
        ram_we_o   = state == WRITE;
        ram_addr_o = addr_q;
        ram_data_o = wr_data_q;
        rdata_o    = rdata_q;
        busy_o     = state != IDLE;
        done_o     = state == DONE;
        err_o      = err_q;
    end
endmodule
